// File: rtl/kbd_pkg.sv
// Shared constants and types for the PS/2 set-2 scancode to ASCII decoder.
// Holds the prefix/modifier scancodes, ASCII control values and parser states.
package kbd_pkg;

  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CTRL   = 8'h14;
  localparam logic [7:0] SC_CAPS   = 8'h58;

  localparam logic [7:0] ASCII_NUL       = 8'h00;
  localparam logic [7:0] ASCII_BS        = 8'h08;
  localparam logic [7:0] ASCII_TAB       = 8'h09;
  localparam logic [7:0] ASCII_CR        = 8'h0D;
  localparam logic [7:0] ASCII_SPACE     = 8'h20;
  localparam logic [7:0] ASCII_CASE_BIT  = 8'h20;
  localparam logic [7:0] ASCII_CTRL_MASK = 8'h1F;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BRK     = 2'd1,
    EXT     = 2'd2,
    EXT_BRK = 2'd3
  } kbd_state_e;

  // Non-extended scancodes that only change modifier state and never produce a character.
  function automatic logic isModifier(input logic [7:0] sc);
    return (sc == SC_LSHIFT) || (sc == SC_RSHIFT) || (sc == SC_CTRL) || (sc == SC_CAPS);
  endfunction

endpackage

// File: rtl/kbd_ascii_map.sv
// Combinational US-layout lookup from a set-2 make code to ASCII.
// Letters come out lowercase unless shift is set; the caller applies caps lock and ctrl.
module kbd_ascii_map
  import kbd_pkg::*;
(
  input  logic [7:0] scancode,
  input  logic       shift,
  output logic [7:0] ascii,
  output logic       is_letter,
  output logic       hit
);

  logic [7:0] lower;
  logic [7:0] upper;

  // Letters list only the lowercase form; the uppercase form is derived by flipping the case bit.
  always_comb begin
    lower = ASCII_NUL;
    upper = ASCII_NUL;
    hit   = 1'b1;
    case (scancode)
      8'h1C: lower = "a";
      8'h32: lower = "b";
      8'h21: lower = "c";
      8'h23: lower = "d";
      8'h24: lower = "e";
      8'h2B: lower = "f";
      8'h34: lower = "g";
      8'h33: lower = "h";
      8'h43: lower = "i";
      8'h3B: lower = "j";
      8'h42: lower = "k";
      8'h4B: lower = "l";
      8'h3A: lower = "m";
      8'h31: lower = "n";
      8'h44: lower = "o";
      8'h4D: lower = "p";
      8'h15: lower = "q";
      8'h2D: lower = "r";
      8'h1B: lower = "s";
      8'h2C: lower = "t";
      8'h3C: lower = "u";
      8'h2A: lower = "v";
      8'h1D: lower = "w";
      8'h22: lower = "x";
      8'h35: lower = "y";
      8'h1A: lower = "z";
      8'h45: begin lower = "0"; upper = ")"; end
      8'h16: begin lower = "1"; upper = "!"; end
      8'h1E: begin lower = "2"; upper = "@"; end
      8'h26: begin lower = "3"; upper = "#"; end
      8'h25: begin lower = "4"; upper = "$"; end
      8'h2E: begin lower = "5"; upper = "%"; end
      8'h36: begin lower = "6"; upper = "^"; end
      8'h3D: begin lower = "7"; upper = "&"; end
      8'h3E: begin lower = "8"; upper = "*"; end
      8'h46: begin lower = "9"; upper = "("; end
      8'h0E: begin lower = 8'h60; upper = "~"; end
      8'h4E: begin lower = "-"; upper = "_"; end
      8'h55: begin lower = "="; upper = "+"; end
      8'h5D: begin lower = "\\"; upper = "|"; end
      8'h54: begin lower = "["; upper = "{"; end
      8'h5B: begin lower = "]"; upper = "}"; end
      8'h4C: begin lower = ";"; upper = ":"; end
      8'h52: begin lower = "'"; upper = "\""; end
      8'h41: begin lower = ","; upper = "<"; end
      8'h49: begin lower = "."; upper = ">"; end
      8'h4A: begin lower = "/"; upper = "?"; end
      8'h29: lower = ASCII_SPACE;
      8'h5A: lower = ASCII_CR;
      8'h66: lower = ASCII_BS;
      8'h0D: lower = ASCII_TAB;
      default: hit = 1'b0;
    endcase
    is_letter = (lower >= "a") && (lower <= "z");
    if (is_letter) begin
      upper = lower ^ ASCII_CASE_BIT;
    end else if (upper == ASCII_NUL) begin
      upper = lower;
    end
    ascii = shift ? upper : lower;
  end

endmodule

// File: rtl/kbd_ascii_decoder.sv
// PS/2 set-2 keyboard decoder: prefix parser, modifier tracking, repeat filter
// and a character FIFO presented as a valid/ready stream.
module kbd_ascii_decoder
  import kbd_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int REPEAT_EN  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sc_valid,
  input  logic [7:0] sc_data,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [7:0] out_ascii,
  output logic       shift_o,
  output logic       caps_o,
  output logic       ctrl_o,
  output logic       overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  typedef logic [AW:0] ptr_t;

  kbd_state_e state_q, state_d;
  logic       lShift_q, lShift_d, rShift_q, rShift_d;
  logic       lCtrl_q, lCtrl_d, rCtrl_q, rCtrl_d;
  logic       capsHeld_q, capsHeld_d, caps_q, caps_d;
  logic [7:0] lastMake_q, lastMake_d;
  logic       isMake, isBreak, isExt, isRepeat;

  logic [7:0] mapAscii;
  logic       mapLetter, mapHit;
  logic       pushReq;
  logic [7:0] pushChar;

  ptr_t       wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic       overflow_q, overflow_d;
  logic       empty, full, doPush, doPop;
  logic [7:0] mem [FIFO_DEPTH];

  assign shift_o  = lShift_q | rShift_q;
  assign ctrl_o   = lCtrl_q | rCtrl_q;
  assign caps_o   = caps_q;
  assign overflow = overflow_q;

  kbd_ascii_map u_map (
    .scancode  (sc_data),
    .shift     (shift_o),
    .ascii     (mapAscii),
    .is_letter (mapLetter),
    .hit       (mapHit)
  );

  // Parser classifies each byte as a prefix, a make or a break, then updates modifiers.
  always_comb begin
    state_d    = state_q;
    lShift_d   = lShift_q;
    rShift_d   = rShift_q;
    lCtrl_d    = lCtrl_q;
    rCtrl_d    = rCtrl_q;
    capsHeld_d = capsHeld_q;
    caps_d     = caps_q;
    lastMake_d = lastMake_q;
    isMake     = 1'b0;
    isBreak    = 1'b0;
    isExt      = 1'b0;
    if (sc_valid) begin
      case (state_q)
        IDLE: begin
          if (sc_data == SC_BREAK)    state_d = BRK;
          else if (sc_data == SC_EXT) state_d = EXT;
          else                        isMake  = 1'b1;
        end
        BRK: begin
          isBreak = 1'b1;
          state_d = IDLE;
        end
        EXT: begin
          if (sc_data == SC_BREAK) begin
            state_d = EXT_BRK;
          end else begin
            isMake  = 1'b1;
            isExt   = 1'b1;
            state_d = IDLE;
          end
        end
        EXT_BRK: begin
          isBreak = 1'b1;
          isExt   = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    if (isMake && !isExt) begin
      case (sc_data)
        SC_LSHIFT: lShift_d = 1'b1;
        SC_RSHIFT: rShift_d = 1'b1;
        SC_CTRL:   lCtrl_d  = 1'b1;
        SC_CAPS: begin
          if (!capsHeld_q) caps_d = ~caps_q;
          capsHeld_d = 1'b1;
        end
        default: ;
      endcase
    end
    if (isBreak && !isExt) begin
      case (sc_data)
        SC_LSHIFT: lShift_d   = 1'b0;
        SC_RSHIFT: rShift_d   = 1'b0;
        SC_CTRL:   lCtrl_d    = 1'b0;
        SC_CAPS:   capsHeld_d = 1'b0;
        default: ;
      endcase
    end
    if (isExt && sc_data == SC_CTRL) begin
      if (isMake)  rCtrl_d = 1'b1;
      if (isBreak) rCtrl_d = 1'b0;
    end

    if (isMake)  lastMake_d = sc_data;
    if (isBreak) lastMake_d = 8'h00;
  end

  // Ctrl wins over case for letters; caps lock only flips the case of letters.
  always_comb begin
    isRepeat = (sc_data == lastMake_q);
    pushReq  = isMake && !isExt && !isModifier(sc_data) && mapHit &&
               (!isRepeat || (REPEAT_EN != 0));
    pushChar = mapAscii;
    if (mapLetter) begin
      if (ctrl_o)      pushChar = mapAscii & ASCII_CTRL_MASK;
      else if (caps_q) pushChar = mapAscii ^ ASCII_CASE_BIT;
    end
  end

  always_comb begin
    empty      = (wrPtr_q == rdPtr_q);
    full       = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
    doPop      = !empty && out_ready;
    doPush     = pushReq && (!full || doPop);
    wrPtr_d    = doPush ? wrPtr_q + ptr_t'(1) : wrPtr_q;
    rdPtr_d    = doPop ? rdPtr_q + ptr_t'(1) : rdPtr_q;
    overflow_d = overflow_q | (pushReq && full && !doPop);
    out_valid  = !empty;
    out_ascii  = empty ? ASCII_NUL : mem[rdPtr_q[AW-1:0]];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      lShift_q   <= 1'b0;
      rShift_q   <= 1'b0;
      lCtrl_q    <= 1'b0;
      rCtrl_q    <= 1'b0;
      capsHeld_q <= 1'b0;
      caps_q     <= 1'b0;
      lastMake_q <= 8'h00;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lShift_q   <= lShift_d;
      rShift_q   <= rShift_d;
      lCtrl_q    <= lCtrl_d;
      rCtrl_q    <= rCtrl_d;
      capsHeld_q <= capsHeld_d;
      caps_q     <= caps_d;
      lastMake_q <= lastMake_d;
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: the empty flag masks stale entries from the output.
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr_q[AW-1:0]] <= pushChar;
  end

endmodule
